// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the register-file port controller and its arbiter.
package mem_ctrl_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 4;
    localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // One-hot pick between two requesters; ptr names the client favoured on a conflict.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] gnt;
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advances on update.
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Pointer moves to the client that was not just served.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= o_gnt[0];
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Candidate grant, only acted upon when the caller pulses i_update.
    always_comb begin
        o_gnt = rr_pick(i_req, r_ptr);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer for an edge-written register file: glitch-safe write strobe, registered
// read data, two-client round-robin arbitration and a whole-array clear sweep.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = MEM_ADDR_W,
    parameter int                DATA_W    = MEM_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VALUE = {DATA_W{1'b0}}
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_clr_req,
    output logic              o_clr_done,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_in,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_out
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            r_state, w_state_nxt;
    logic              r_is_clr, r_is_wr, r_owner;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        w_arb_gnt;
    logic              w_accept, w_start_clr, w_to_done;
    mem_req_t          w_sel_req;

    logic              r_gnt0, r_gnt1, r_ack0, r_ack1, r_clr_done, r_busy, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data, w_mem_data_nxt, r_rdata, w_rdata_nxt;

    assign w_start_clr = (r_state == IDLE) && i_clr_req;
    assign w_accept    = (r_state == IDLE) && !i_clr_req && (|w_arb_gnt);
    assign w_to_done   = (w_state_nxt == DONE) && (r_state != DONE);

    rr_arbiter2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({i_req1, i_req0}),
        .i_update(w_accept),
        .o_gnt   (w_arb_gnt)
    );

    // Request fields of whichever client the arbiter currently favours.
    always_comb begin
        if (w_arb_gnt[1]) begin
            w_sel_req = '{we: i_we1, addr: i_addr1, wdata: i_wdata1};
        end else begin
            w_sel_req = '{we: i_we0, addr: i_addr0, wdata: i_wdata0};
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the sweep loops SETUP->STROBE->RELEASE until the counter saturates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_clr || w_accept) w_state_nxt = SETUP;
                else                         w_state_nxt = IDLE;
            end
            SETUP: begin
                if (r_is_clr || r_is_wr) w_state_nxt = STROBE;
                else                     w_state_nxt = DONE;
            end
            STROBE:  w_state_nxt = RELEASE;
            RELEASE: begin
                if (r_is_clr && !(&r_cnt)) w_state_nxt = SETUP;
                else                       w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Transaction context latched on accept; sweep counter advances after each clear write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_is_clr <= 1'b0;
            r_is_wr  <= 1'b0;
            r_owner  <= 1'b0;
            r_cnt    <= {ADDR_W{1'b0}};
        end else if (w_start_clr) begin
            r_is_clr <= 1'b1;
            r_is_wr  <= 1'b0;
            r_cnt    <= {ADDR_W{1'b0}};
        end else if (w_accept) begin
            r_is_clr <= 1'b0;
            r_is_wr  <= w_sel_req.we;
            r_owner  <= w_arb_gnt[1];
        end else if (r_state == RELEASE && r_is_clr) begin
            r_cnt    <= r_cnt + ADDR_ONE;
        end else begin
            r_cnt    <= r_cnt;
        end
    end

    // Memory bus only moves on entry to SETUP, never alongside a strobe edge.
    always_comb begin
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        if (w_state_nxt == SETUP) begin
            if (w_accept) begin
                w_mem_addr_nxt = w_sel_req.addr;
                w_mem_data_nxt = w_sel_req.wdata;
            end else if (w_start_clr) begin
                w_mem_addr_nxt = {ADDR_W{1'b0}};
                w_mem_data_nxt = CLR_VALUE;
            end else begin
                w_mem_addr_nxt = r_cnt + ADDR_ONE;
                w_mem_data_nxt = CLR_VALUE;
            end
        end else begin
            w_mem_addr_nxt = r_mem_addr;
            w_mem_data_nxt = r_mem_data;
        end
        if (r_state == SETUP && !r_is_wr && !r_is_clr) begin
            w_rdata_nxt = i_mem_data_out;
        end else begin
            w_rdata_nxt = r_rdata;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_clr_done <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_mem_data <= {DATA_W{1'b0}};
            r_rdata    <= {DATA_W{1'b0}};
        end else begin
            r_gnt0     <= w_accept && w_arb_gnt[0];
            r_gnt1     <= w_accept && w_arb_gnt[1];
            r_ack0     <= w_to_done && !r_is_clr && !r_owner;
            r_ack1     <= w_to_done && !r_is_clr && r_owner;
            r_clr_done <= w_to_done && r_is_clr;
            r_busy     <= (w_state_nxt != IDLE);
            r_mem_we   <= (w_state_nxt == STROBE);
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    assign o_gnt0             = r_gnt0;
    assign o_gnt1             = r_gnt1;
    assign o_ack0             = r_ack0;
    assign o_ack1             = r_ack1;
    assign o_clr_done         = r_clr_done;
    assign o_busy             = r_busy;
    assign o_mem_write_enable = r_mem_we;
    assign o_mem_address      = r_mem_addr;
    assign o_mem_data_in      = r_mem_data;
    assign o_rdata            = r_rdata;

endmodule
